// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_F    = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

endpackage

// File: rtl/mem_arb_fair_ctr.sv
// Starvation guard: counts back-to-back data grants taken while a fetch waits
// and forces a fetch grant once the burst limit is reached.
module mem_arb_fair_ctr #(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic f_req,
  input  logic grant_f,
  input  logic grant_d,
  output logic force_f
);

  localparam int CW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DATA_BURST);

  logic [CW-1:0] dcnt_q;
  logic [CW-1:0] dcnt_d;

  always_comb begin
    dcnt_d = dcnt_q;
    if (grant_f) begin
      dcnt_d = '0;
    end else if (grant_d) begin
      if (!f_req) begin
        dcnt_d = '0;
      end else if (dcnt_q != MAX_CNT) begin
        dcnt_d = dcnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end

  assign force_f = f_req && (dcnt_q == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one synchronous-read memory between fetch and load/store ports.
// Optional fetch-starvation guard enabled by defining MEM_ARB_FAIR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t state_q, state_d;
  logic       dwe_q, dwe_d;
  grant_t     grant;
  logic       grant_f, grant_d;
  logic       force_f;

`ifdef MEM_ARB_FAIR_EN
  mem_arb_fair_ctr #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_fair_ctr (
    .clk    (clk),
    .rst    (rst),
    .f_req  (f_req),
    .grant_f(grant_f),
    .grant_d(grant_d),
    .force_f(force_f)
  );
`else
  logic burst_unused;
  assign burst_unused = (MAX_DATA_BURST >= 1);
  assign force_f = 1'b0;
`endif

  // Grants are only made from IDLE; reset suppresses any issue that cycle.
  always_comb begin
    grant = GNT_NONE;
    if (state_q == IDLE && !rst) begin
      if (d_req && !force_f) begin
        grant = GNT_D;
      end else if (f_req) begin
        grant = GNT_F;
      end
    end
  end

  assign grant_f = (grant == GNT_F);
  assign grant_d = (grant == GNT_D);

  always_comb begin
    state_d = IDLE;
    dwe_d   = dwe_q;
    case (grant)
      GNT_F:   state_d = BUSY_F;
      GNT_D: begin
        state_d = BUSY_D;
        dwe_d   = d_we;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwe_q   <= dwe_d;
    end
  end

  always_comb begin
    mem_en    = grant_f || grant_d;
    mem_we    = grant_d && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_d) begin
      mem_addr = d_addr;
    end else if (grant_f) begin
      mem_addr = f_addr;
    end
    if (mem_we) begin
      mem_wdata = d_wdata;
    end
  end

  // Ack cycle: memory read data passes straight through; a reset here kills the ack.
  always_comb begin
    f_ack   = (state_q == BUSY_F) && !rst;
    d_ack   = (state_q == BUSY_D) && !rst;
    f_rdata = f_ack ? mem_rdata : '0;
    d_rdata = (d_ack && !dwe_q) ? mem_rdata : '0;
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus collision, fairness and
// mid-operation reset sequences against a small synchronous-read memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic [31:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_cmp;
  int n_err;

  logic [0:0] exp_q[$];

  mem_arbiter #(
    .AW(32),
    .DW(32),
    .MAX_DATA_BURST(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_ack    (f_ack),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: 256 words, synchronous read, preloaded during reset
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h10] <= 32'hDEAD_BEEF;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_fack;
    logic        e_dack;
    logic [31:0] e_frd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    f_req   = 1'b0;
    f_addr  = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"},    {31'b0, mem_en},    32'h0);
    check({tag, "_mem_we"},    {31'b0, mem_we},    32'h0);
    check({tag, "_mem_addr"},  mem_addr,           32'h0);
    check({tag, "_mem_wdata"}, mem_wdata,          32'h0);
    check({tag, "_f_ack"},     {31'b0, f_ack},     32'h0);
    check({tag, "_d_ack"},     {31'b0, d_ack},     32'h0);
    check({tag, "_f_rdata"},   f_rdata,            32'h0);
    check({tag, "_d_rdata"},   d_rdata,            32'h0);
    check({tag, "_busy"},      {31'b0, busy},      32'h0);
  endtask

  task automatic run_vec(input int i);
    string t;
    t = $sformatf("v%0d", i);
    f_req   = vecs[i].f_req;
    f_addr  = vecs[i].f_addr;
    d_req   = vecs[i].d_req;
    d_we    = vecs[i].d_we;
    d_addr  = vecs[i].d_addr;
    d_wdata = vecs[i].d_wdata;
    @(negedge clk);
    check({t, "_issue_en"},    {31'b0, mem_en}, {31'b0, vecs[i].e_en});
    check({t, "_issue_we"},    {31'b0, mem_we}, {31'b0, vecs[i].e_we});
    check({t, "_issue_addr"},  mem_addr,        vecs[i].e_addr);
    check({t, "_issue_wdata"}, mem_wdata,       vecs[i].e_wdata);
    check({t, "_issue_busy"},  {31'b0, busy},   32'h0);
    step();
    @(negedge clk);
    check({t, "_f_ack"},   {31'b0, f_ack},  {31'b0, vecs[i].e_fack});
    check({t, "_d_ack"},   {31'b0, d_ack},  {31'b0, vecs[i].e_dack});
    check({t, "_f_rdata"}, f_rdata,         vecs[i].e_frd);
    check({t, "_d_rdata"}, d_rdata,         vecs[i].e_drd);
    check({t, "_ack_en"},  {31'b0, mem_en}, 32'h0);
    check({t, "_ack_busy"}, {31'b0, busy},  {31'b0, vecs[i].f_req | vecs[i].d_req});
    step();
    drive_idle();
    @(negedge clk);
    check_all_zero({t, "_after"});
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,
                1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,
                1'b1, 1'b0, 32'h10, 32'h0,  1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h5,  32'h1234,
                1'b1, 1'b1, 32'h5,  32'h1234, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h5,  32'hFFFF,
                1'b1, 1'b0, 32'h5,  32'h0,  1'b0, 1'b1, 32'h0, 32'h1234};
    vecs[4] = '{1'b1, 32'h5,  1'b0, 1'b0, 32'h0,  32'h0,
                1'b1, 1'b0, 32'h5,  32'h0,  1'b1, 1'b0, 32'h1234, 32'h0};
    vecs[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hFF, 32'hA5A5_A5A5,
                1'b1, 1'b1, 32'hFF, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[6] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'hFF, 32'h0,
                1'b1, 1'b0, 32'hFF, 32'h0,  1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5};
    vecs[7] = '{1'b1, 32'hFF, 1'b0, 1'b1, 32'h33, 32'h77,
                1'b1, 1'b0, 32'hFF, 32'h0,  1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0};

    // reset: outputs quiet, even with a request already raised
    rst = 1'b1;
    drive_idle();
    step();
    step();
    @(negedge clk);
    check_all_zero("reset");
    f_req  = 1'b1;
    f_addr = 32'h10;
    @(negedge clk);
    check("reset_req_en", {31'b0, mem_en}, 32'h0);
    step();
    rst = 1'b0;
    drive_idle();

    for (int i = 0; i < 8; i++) run_vec(i);

    // collision: data wins, fetch follows two cycles later
    f_req  = 1'b1;
    f_addr = 32'h10;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h5;
    @(negedge clk);
    check("col_issue_addr", mem_addr, 32'h5);
    check("col_issue_en",   {31'b0, mem_en}, 32'h1);
    step();
    @(negedge clk);
    check("col_d_ack",   {31'b0, d_ack}, 32'h1);
    check("col_d_rdata", d_rdata,        32'h1234);
    check("col_f_ack0",  {31'b0, f_ack}, 32'h0);
    step();
    d_req = 1'b0;
    @(negedge clk);
    check("col_f_issue_en",   {31'b0, mem_en}, 32'h1);
    check("col_f_issue_addr", mem_addr,        32'h10);
    step();
    @(negedge clk);
    check("col_f_ack",   {31'b0, f_ack}, 32'h1);
    check("col_f_rdata", f_rdata,        32'hDEAD_BEEF);
    step();
    drive_idle();

    // sustained contention: ack order against the expected queue
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_FAIR_EN
      exp_q.push_back((k % 5 == 4) ? 1'b1 : 1'b0);
`else
      exp_q.push_back(1'b0);
`endif
    end
    f_req  = 1'b1;
    f_addr = 32'h10;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h5;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        if (exp_q.size() == 0) begin
          check("fair_extra_ack", {31'b0, f_ack}, 32'h2);
        end else begin
          check($sformatf("fair_ack%0d_is_fetch", c), {31'b0, f_ack}, {31'b0, exp_q.pop_front()});
        end
      end
      step();
    end
    check("fair_acks_left", exp_q.size(), 32'h0);
    drive_idle();
    step();

    // reset in the data ack cycle: no ack, quiet, then re-issue
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h5;
    @(negedge clk);
    check("rmid_issue_en", {31'b0, mem_en}, 32'h1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rmid_d_ack",   {31'b0, d_ack}, 32'h0);
    check("rmid_d_rdata", d_rdata,        32'h0);
    step();
    @(negedge clk);
    check_all_zero("rmid_next");
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rmid_reissue_en",   {31'b0, mem_en}, 32'h1);
    check("rmid_reissue_addr", mem_addr,        32'h5);
    step();
    @(negedge clk);
    check("rmid_d_ack2",   {31'b0, d_ack}, 32'h1);
    check("rmid_d_rdata2", d_rdata,        32'h1234);
    step();
    drive_idle();
    @(negedge clk);
    check_all_zero("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
